feynman_tcam_compare: RTL and testbench
=======================================

Name: feynman_tcam_compare

Overview:
Pipelined, parametrised ternary comparator built on the Feynman (reversible XOR) primitive. Each accepted transaction carries a search key, a stored word and a don't-care mask.
- Per bit, the block forms P = key (fan-out copy) and Q = key XOR word.
- It masks Q, reduces it to a match flag and a mismatch count, and returns these downstream through a valid/ready handshake.
- It sits between the TCAM key driver and the match-line priority logic, and also keeps a saturating hit counter.

Parameters:
DATA_W, 16, bits per key/word/mask; must be a multiple of CHUNK_W.
CHUNK_W, 4, bits OR-reduced per chunk in stage 2.
HIT_W, 16, width of the saturating hit counter.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input transaction present.
in_ready  out  1  block can accept this cycle.
in_key  in  DATA_W  search key (Feynman A input).
in_word  in  DATA_W  stored word (Feynman B input).
in_mask  in  DATA_W  1 = don't-care bit.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts.
out_key  out  DATA_W  P output: unmodified copy of in_key.
out_diff  out  DATA_W  (key XOR word) AND NOT mask.
out_match  out  1  1 when out_diff == 0.
out_miss_cnt  out  $clog2(DATA_W+1)  popcount of out_diff.
hit_cnt  out  HIT_W  number of matching results transferred at the output.
hit_clr  in  1  synchronous clear of hit_cnt.

Behaviour:
- Reset (async assert, sync-to-clk release not required inside the block):
  - all stage valid bits = 0; out_valid = 0.
  - out_key, out_diff, out_miss_cnt = 0; out_match = 0; hit_cnt = 0.
  - in_ready = 1 from the first clock after rst deasserts.
- Asserting rst mid-operation discards all in-flight transactions. No partial result is ever presented.
- Pipeline: 3 register stages; latency exactly 3 cycles from input handshake to out_valid when out_ready is held 1.
  - S1 registers key and diff = (key ^ word) & ~mask.
  - S2 registers key, diff, DATA_W/CHUNK_W chunk-OR flags and per-chunk popcounts.
  - S3 registers key, diff, match = NOR of the chunk flags, and miss_cnt = sum of the chunk popcounts.
- Handshake:
  - A stage loads when it is empty or when its contents move forward that cycle.
  - in_ready = ~S1.valid | S1 advancing; a transfer occurs on in_valid & in_ready.
  - An output transfer occurs on out_valid & out_ready.
  - Full throughput: one transaction per cycle while out_ready = 1.
  - Under backpressure, stages fill and hold their data unchanged. in_ready falls only when all 3 stages are full and out_ready = 0.
  - No combinational path from in_valid to out_valid. in_ready may depend combinationally on out_ready.
- Data stability: while out_valid = 1 and out_ready = 0, all out_* signals hold.
- Reversibility invariant: out_key ^ out_diff equals in_word on every bit where mask = 0.
- hit_cnt:
  - Increments by 1 on each output transfer with out_match = 1 and saturates at 2^HIT_W − 1.
  - hit_clr has priority: when it coincides with a counted transfer, hit_cnt becomes 0 and that transfer is not counted.
- Edge cases:
  - An all-ones mask always matches, with miss_cnt = 0.
  - All-zeros mask with word = ~key gives match = 0 and miss_cnt = DATA_W.

Decomposition:
- Shared package tcam_pkg: DATA_W/CHUNK_W defaults, CNT_W = $clog2(DATA_W+1), and the typedef for the stage payload struct (key, diff, valid).
- One natural sub-module: feynman_gate_vec, a DATA_W-wide Feynman array (P = A, Q = A ^ B) instantiated in S1. Reduction logic stays in the top module.

Test Plan:
- Single transaction: key = 16'hA5A5, word = 16'hA5A5, mask = 0, out_ready = 1 → out_valid at cycle +3, match = 1, miss_cnt = 0, diff = 0, out_key = 16'hA5A5, hit_cnt = 1.
- Mask coverage: key = 16'h00FF, word = 16'h0000, mask = 16'h00FF → match = 1. Same with mask = 16'h000F → match = 0, miss_cnt = 4, diff = 16'h00F0.
- Streaming: 8 back-to-back transactions, out_ready = 1 → 8 results on 8 consecutive cycles, in order, in_ready constantly 1.
- Backpressure: stream 5 transactions, out_ready = 0 from cycle 2 → in_ready = 0 once 3 stages are full, outputs stable. Releasing out_ready delivers all 5 in order with no loss or duplication.
- Counter: HIT_W = 4, 17 matching transfers → hit_cnt = 15. hit_clr coincident with a matching transfer → hit_cnt = 0.
- Reset mid-flight: assert rst with 3 transactions in flight → out_valid = 0 and hit_cnt = 0 immediately. After release, no stale result appears.

Source files
------------

// File: rtl/tcam_pkg.sv
// tcam_pkg: shared widths, stage payload type and popcount helper for the TCAM comparator.
package tcam_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CHUNK_W = 4;
  localparam int CNT_W = $clog2(DEF_DATA_W + 1);
  typedef struct packed {
    logic [DEF_DATA_W-1:0] key;
    logic [DEF_DATA_W-1:0] diff;
    logic                  valid;
  } stage_t;
  function automatic int unsigned popcnt(input logic [31:0] v);
    popcnt = 0;
    for (int i = 0; i < 32; i++) popcnt += {31'b0, v[i]};
  endfunction
endpackage

// File: rtl/feynman_gate_vec.sv
// feynman_gate_vec: W-wide array of reversible Feynman gates (P = A, Q = A ^ B).
module feynman_gate_vec #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o,
  output logic [W-1:0] q_o
);
  assign p_o = a_i;
  assign q_o = a_i ^ b_i;
endmodule

// File: rtl/feynman_tcam_compare.sv
// feynman_tcam_compare: 3-stage ternary key/word comparator with match flag, mismatch count and hit counter.
module feynman_tcam_compare
  import tcam_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int HIT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_key,
  input  logic [DATA_W-1:0]          in_word,
  input  logic [DATA_W-1:0]          in_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_key,
  output logic [DATA_W-1:0]          out_diff,
  output logic                       out_match,
  output logic [$clog2(DATA_W+1)-1:0] out_miss_cnt,
  output logic [HIT_W-1:0]           hit_cnt,
  input  logic                       hit_clr
);
  localparam int NC = DATA_W / CHUNK_W;
  localparam int PW = $clog2(CHUNK_W + 1);
  localparam int MW = $clog2(DATA_W + 1);
  stage_t s1_q, s2_q, s3_q;
  logic [NC-1:0] f2_q, f2_d;
  logic [NC-1:0][PW-1:0] p2_q, p2_d;
  logic m3_q, m3_d;
  logic [MW-1:0] c3_q, c3_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [DATA_W-1:0] p, q;
  logic adv1, adv2, adv3;
  feynman_gate_vec #(.W(DATA_W)) u_fg (.a_i(in_key), .b_i(in_word), .p_o(p), .q_o(q));
  // each stage moves when it is empty or its successor is moving
  assign adv3 = ~s3_q.valid | out_ready;
  assign adv2 = ~s2_q.valid | adv3;
  assign adv1 = ~s1_q.valid | adv2;
  assign in_ready = adv1;
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      f2_d[i] = |s1_q.diff[i*CHUNK_W +: CHUNK_W];
      p2_d[i] = PW'(popcnt(32'(s1_q.diff[i*CHUNK_W +: CHUNK_W])));
    end
    m3_d = ~|f2_q;
    c3_d = '0;
    for (int i = 0; i < NC; i++) c3_d = c3_d + MW'(p2_q[i]);
    hit_d = hit_clr ? '0 : (out_valid & out_ready & m3_q & ~&hit_q) ? hit_q + 1'b1 : hit_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      f2_q  <= '0;
      p2_q  <= '0;
      m3_q  <= 1'b0;
      c3_q  <= '0;
      hit_q <= '0;
    end else begin
      if (adv1) s1_q <= '{key: p, diff: q & ~in_mask, valid: in_valid};
      if (adv2) begin
        s2_q <= s1_q;
        f2_q <= f2_d;
        p2_q <= p2_d;
      end
      if (adv3) begin
        s3_q <= s2_q;
        m3_q <= m3_d;
        c3_q <= c3_d;
      end
      hit_q <= hit_d;
    end
  end
  assign out_valid    = s3_q.valid;
  assign out_key      = s3_q.key;
  assign out_diff     = s3_q.diff;
  assign out_match    = m3_q;
  assign out_miss_cnt = c3_q;
  assign hit_cnt      = hit_q;
endmodule

// File: tb/tb_feynman_tcam_compare.sv
// tb_feynman_tcam_compare: scoreboard bench with directed and random traffic against a spec-level model.
module tb_feynman_tcam_compare;
  localparam int DW = 16;
  localparam int HW = 4;
  localparam int CW = $clog2(DW + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_key = '0, in_word = '0, in_mask = '0;
  logic out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_key, out_diff;
  logic out_match;
  logic [CW-1:0] out_miss_cnt;
  logic [HW-1:0] hit_cnt;
  logic hit_clr = 1'b0;
  typedef struct {
    logic [DW-1:0] key;
    logic [DW-1:0] diff;
    logic          match;
    int            miss;
    int            acc;
    bit            lat;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, hit_m = 0;
  bit lat_mode = 0, rnd_done = 0;
  feynman_tcam_compare #(.DATA_W(DW), .CHUNK_W(4), .HIT_W(HW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_word(in_word), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_diff(out_diff), .out_match(out_match), .out_miss_cnt(out_miss_cnt),
    .hit_cnt(hit_cnt), .hit_clr(hit_clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask
  // monitor: pops the scoreboard on every output transfer and tracks the hit counter
  initial begin
    exp_t e;
    bit stall = 0, xfer;
    logic [DW-1:0] sk, sd;
    logic sm;
    logic [CW-1:0] sc;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        hit_m = 0;
        stall = 0;
      end else begin
        chk("hit_cnt", 32'(hit_cnt), hit_m);
        if (stall) begin
          chk("hold_key", out_key, sk);
          chk("hold_diff", out_diff, sd);
          chk("hold_match", out_match, sm);
          chk("hold_miss", out_miss_cnt, sc);
        end
        xfer = 0;
        if (out_valid && sb.size() == 0) fail_now("unexpected_output");
        else if (out_valid && out_ready) begin
          e = sb.pop_front();
          xfer = 1;
          chk("out_key", out_key, e.key);
          chk("out_diff", out_diff, e.diff);
          chk("out_match", out_match, e.match);
          chk("out_miss_cnt", out_miss_cnt, e.miss);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
        if (hit_clr) hit_m = 0;
        else if (xfer && e.match && hit_m < (1 << HW) - 1) hit_m++;
        stall = out_valid & ~out_ready;
        sk = out_key; sd = out_diff; sm = out_match; sc = out_miss_cnt;
      end
    end
  end
  task automatic send(input logic [DW-1:0] k, input logic [DW-1:0] w, input logic [DW-1:0] m);
    exp_t e;
    int t = 0;
    logic [DW-1:0] d;
    in_key = k; in_word = w; in_mask = m; in_valid = 1'b1;
    @(negedge clk);
    if (lat_mode) chk("in_ready_stream", in_ready, 1);
    while (!in_ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    d = (k ^ w) & ~m;
    e.key = k; e.diff = d; e.match = (d == 0); e.miss = $countones(d);
    e.acc = cyc; e.lat = lat_mode;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      t++;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [DW-1:0] k, w, m;
    int t;
    tick(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_out_diff", out_diff, 0);
    chk("rst_out_match", out_match, 0);
    chk("rst_miss", out_miss_cnt, 0);
    chk("rst_hit", hit_cnt, 0);
    rst = 1'b0;
    tick(1);
    chk("in_ready_after_rst", in_ready, 1);
    lat_mode = 1;
    send(16'hA5A5, 16'hA5A5, 16'h0000);
    drain();
    chk("hit_after_first", hit_cnt, 1);
    send(16'h00FF, 16'h0000, 16'h00FF);
    send(16'h00FF, 16'h0000, 16'h000F);
    send(16'h1234, 16'h9876, 16'hFFFF);
    send(16'h5A3C, 16'hA5C3, 16'h0000);
    drain();
    for (int i = 0; i < 8; i++) begin
      k = 16'($urandom);
      send(k, (i % 2 == 0) ? k : 16'($urandom), 16'($urandom) & 16'($urandom));
    end
    drain();
    lat_mode = 0;
    // backpressure: output stalls once the first result is near the end of the pipe
    fork
      for (int i = 0; i < 5; i++) begin
        k = 16'($urandom);
        send(k, k ^ 16'(i), 16'h0000);
      end
      begin
        tick(2);
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        tick(1);
        out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 17; i++) begin
      k = 16'($urandom);
      send(k, k, 16'($urandom));
    end
    drain();
    chk("hit_saturated", hit_cnt, 4'hF);
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0F0F, 16'h0000);
    t = 0;
    while (!out_valid && t < 50) begin
      t++;
      tick(1);
    end
    if (!out_valid) fail_now("clr_wait_timeout");
    hit_clr = 1'b1;
    out_ready = 1'b1;
    tick(1);
    hit_clr = 1'b0;
    chk("hit_clr_priority", hit_cnt, 0);
    drain();
    send(16'h7777, 16'h7777, 16'h0000);
    drain();
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 16'h0000);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_hit", hit_cnt, 0);
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("post_rst_idle", out_valid, 0);
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          k = 16'($urandom);
          m = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom) & 16'($urandom);
          w = $urandom_range(0, 1) ? (k ^ (16'($urandom) & m)) : 16'($urandom);
          send(k, w, m);
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        tick(1);
        out_ready = ($urandom_range(0, 3) != 0);
        hit_clr = ($urandom_range(0, 19) == 0);
      end
    join
    out_ready = 1'b1;
    hit_clr = 1'b0;
    drain();
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
